// File: rtl/vita49_pkg.sv
// Shared VITA49 definitions used by the packer and the unpacker:
// FSM encodings, ctrl bit indices, header field codes, byte-order helper.
package vita49_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        STRM_ID = 3'd2,
        TSI     = 3'd3,
        TSF_0   = 3'd4,
        TSF_1   = 3'd5,
        PAYLOAD = 3'd6,
        PAD     = 3'd7
    } v49_state_t;

    localparam int CTRL_START  = 0;
    localparam int CTRL_SRST   = 1;
    localparam int CTRL_PASS   = 2;
    localparam int CTRL_TSI_EN = 3;
    localparam int CTRL_TSF_EN = 4;

    localparam logic [3:0] PKT_TYPE_IF_SID = 4'b0001;
    localparam logic [1:0] TSI_UTC         = 2'b01;
    localparam logic [1:0] TSF_SAMPLE      = 2'b10;

    function automatic logic [31:0] net_order(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/vita49_out_reg.sv
// One-entry AXI-Stream output register with valid/ready handshake.
// Ports: clk/async reset, clr (sync flush), ld/ld_data/ld_last load request,
// m_tready in, m_tdata/m_tvalid/m_tlast out, can_load (slot free this cycle).
module vita49_out_reg (
    input  logic        AXIS_ACLK,
    input  logic        AXIS_ARESETN,
    input  logic        clr,
    input  logic        ld,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    input  logic        m_tready,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    output logic        can_load
);

    assign can_load = !m_tvalid || m_tready;

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            m_tvalid <= 1'b0;
            m_tdata  <= 32'd0;
            m_tlast  <= 1'b0;
        end else if (clr) begin
            m_tvalid <= 1'b0;
            m_tdata  <= 32'd0;
            m_tlast  <= 1'b0;
        end else if (can_load) begin
            m_tvalid <= ld;
            m_tlast  <= ld && ld_last;
            if (ld) begin
                m_tdata <= ld_data;
            end
        end
    end

endmodule

// File: rtl/vita49_pack.sv
// VITA49 IF-data packer: wraps raw samples in header/stream-id/timestamps.
// Ports: S_AXIS in, M_AXIS out, ctrl/streamID/payload_len/timestamps, counters.
module vita49_pack
    import vita49_pkg::*;
#(
    parameter logic [15:0] MAX_PAYLOAD = 16'd8192
) (
    input  logic        AXIS_ACLK,
    input  logic        AXIS_ARESETN,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TVALID,
    input  logic        S_AXIS_TLAST,
    output logic        S_AXIS_TREADY,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    output logic        M_AXIS_TLAST,
    input  logic        M_AXIS_TREADY,
    input  logic [31:0] ctrl,
    input  logic [31:0] streamID,
    input  logic [15:0] payload_len,
    input  logic [31:0] timestamp_sec,
    input  logic [63:0] timestamp_fsec,
    output logic [31:0] pkt_sent,
    output logic [31:0] pad_events,
    output logic [31:0] status,
    output logic [2:0]  Mstate_dbg
);

    v49_state_t  state_q, state_d;

    logic [4:0]  ctrl_q;
    logic [31:0] sid_q;
    logic [15:0] len_q;
    logic        unused_ctrl;

    logic [31:0] sec_q;
    logic [63:0] fsec_q;
    logic        tsi_q, tsf_q;
    logic [15:0] len_l, eff_len, wcnt, pkt_size;
    logic [3:0]  pkt_cnt;
    logic [31:0] pkt_sent_q, pad_q;

    logic        start, srst, pass;
    logic        ld, ld_last, go, adv, pad_start, done, s_ready;
    logic [31:0] ld_data, hdr;
    logic        can_load, r_valid, r_last, last_word, pt_act;
    logic [31:0] r_data;

    assign unused_ctrl = &{1'b0, ctrl[31:5]};

    assign start = ctrl_q[CTRL_START];
    assign srst  = ctrl_q[CTRL_SRST];
    assign pass  = ctrl_q[CTRL_PASS];

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            ctrl_q <= '0;
            sid_q  <= '0;
            len_q  <= '0;
        end else begin
            ctrl_q <= ctrl[4:0];
            sid_q  <= streamID;
            len_q  <= payload_len;
        end
    end

    always_comb begin
        if (len_q == 16'd0)
            eff_len = 16'd1;
        else if (len_q > MAX_PAYLOAD)
            eff_len = MAX_PAYLOAD;
        else
            eff_len = len_q;
    end

    assign pkt_size = 16'd2 + {15'd0, tsi_q}
                    + {14'd0, tsf_q, 1'b0} + len_l;

    assign hdr = {PKT_TYPE_IF_SID, 1'b0, 1'b0, 2'b00,
                  tsi_q ? TSI_UTC : 2'b00,
                  tsf_q ? TSF_SAMPLE : 2'b00,
                  pkt_cnt, pkt_size};

    assign last_word = (wcnt == len_l - 16'd1);

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        ld        = 1'b0;
        ld_data   = 32'd0;
        ld_last   = 1'b0;
        go        = 1'b0;
        adv       = 1'b0;
        pad_start = 1'b0;
        done      = 1'b0;
        s_ready   = (state_q == PAYLOAD) && can_load;
        unique case (state_q)
            IDLE: begin
                if (start && !pass && S_AXIS_TVALID) begin
                    go      = 1'b1;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (can_load) begin
                    ld      = 1'b1;
                    ld_data = net_order(hdr);
                    state_d = STRM_ID;
                end
            end
            STRM_ID: begin
                if (can_load) begin
                    ld      = 1'b1;
                    ld_data = net_order(sid_q);
                    state_d = tsi_q ? TSI : (tsf_q ? TSF_0 : PAYLOAD);
                end
            end
            TSI: begin
                if (can_load) begin
                    ld      = 1'b1;
                    ld_data = net_order(sec_q);
                    state_d = tsf_q ? TSF_0 : PAYLOAD;
                end
            end
            TSF_0: begin
                if (can_load) begin
                    ld      = 1'b1;
                    ld_data = net_order(fsec_q[63:32]);
                    state_d = TSF_1;
                end
            end
            TSF_1: begin
                if (can_load) begin
                    ld      = 1'b1;
                    ld_data = net_order(fsec_q[31:0]);
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (S_AXIS_TVALID && s_ready) begin
                    ld      = 1'b1;
                    adv     = 1'b1;
                    ld_data = net_order(S_AXIS_TDATA);
                    ld_last = last_word;
                    if (last_word) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else if (S_AXIS_TLAST) begin
                        // short input frame: fill the rest with zeros
                        pad_start = 1'b1;
                        state_d   = PAD;
                    end
                end
            end
            PAD: begin
                if (can_load) begin
                    ld      = 1'b1;
                    adv     = 1'b1;
                    ld_last = last_word;
                    if (last_word) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
        endcase
        if (srst) begin
            state_d = IDLE;
            ld      = 1'b0;
        end
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            sec_q      <= '0;
            fsec_q     <= '0;
            tsi_q      <= 1'b0;
            tsf_q      <= 1'b0;
            len_l      <= 16'd1;
            wcnt       <= '0;
            pkt_cnt    <= '0;
            pkt_sent_q <= '0;
            pad_q      <= '0;
        end else if (srst) begin
            wcnt       <= '0;
            pkt_cnt    <= '0;
            pkt_sent_q <= '0;
            pad_q      <= '0;
        end else begin
            if (go) begin
                sec_q  <= timestamp_sec;
                fsec_q <= timestamp_fsec;
                tsi_q  <= ctrl_q[CTRL_TSI_EN];
                tsf_q  <= ctrl_q[CTRL_TSF_EN];
                len_l  <= eff_len;
                wcnt   <= '0;
            end else if (adv) begin
                wcnt <= wcnt + 16'd1;
            end
            if (done) begin
                pkt_cnt    <= pkt_cnt + 4'd1;
                pkt_sent_q <= pkt_sent_q + 32'd1;
            end
            if (pad_start)
                pad_q <= pad_q + 32'd1;
        end
    end

    vita49_out_reg u_out (
        .AXIS_ACLK    (AXIS_ACLK),
        .AXIS_ARESETN (AXIS_ARESETN),
        .clr          (srst),
        .ld           (ld),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
        .m_tready     (M_AXIS_TREADY),
        .m_tdata      (r_data),
        .m_tvalid     (r_valid),
        .m_tlast      (r_last),
        .can_load     (can_load)
    );

    // bypass only once a packet has fully drained from the register
    assign pt_act = (state_q == IDLE) && pass && !r_valid;

    assign M_AXIS_TDATA  = pt_act ? S_AXIS_TDATA  : r_data;
    assign M_AXIS_TVALID = pt_act ? S_AXIS_TVALID : r_valid;
    assign M_AXIS_TLAST  = pt_act ? S_AXIS_TLAST  : r_last;
    assign S_AXIS_TREADY = pt_act ? M_AXIS_TREADY : s_ready;

    assign pkt_sent   = pkt_sent_q;
    assign pad_events = pad_q;
    assign Mstate_dbg = state_q;
    assign status     = {start, srst, pass, AXIS_ARESETN, 25'd0, state_q};

endmodule

// File: tb/tb_vita49_pack.sv
// Directed self-checking bench for vita49_pack.
// Drives S_AXIS/ctrl, collects M_AXIS words, compares to expected packets.
module tb_vita49_pack;

    logic        AXIS_ACLK;
    logic        AXIS_ARESETN;
    logic [31:0] S_AXIS_TDATA;
    logic        S_AXIS_TVALID;
    logic        S_AXIS_TLAST;
    logic        S_AXIS_TREADY;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TREADY;
    logic [31:0] ctrl;
    logic [31:0] streamID;
    logic [15:0] payload_len;
    logic [31:0] timestamp_sec;
    logic [63:0] timestamp_fsec;
    logic [31:0] pkt_sent;
    logic [31:0] pad_events;
    logic [31:0] status;
    logic [2:0]  Mstate_dbg;

    int checks;
    int failures;

    logic [31:0] src[$];
    bit          srcl[$];
    logic [31:0] got[$];
    bit          gotl[$];
    logic [31:0] exp[$];
    bit          expl[$];

    vita49_pack dut (
        .AXIS_ACLK      (AXIS_ACLK),
        .AXIS_ARESETN   (AXIS_ARESETN),
        .S_AXIS_TDATA   (S_AXIS_TDATA),
        .S_AXIS_TVALID  (S_AXIS_TVALID),
        .S_AXIS_TLAST   (S_AXIS_TLAST),
        .S_AXIS_TREADY  (S_AXIS_TREADY),
        .M_AXIS_TDATA   (M_AXIS_TDATA),
        .M_AXIS_TVALID  (M_AXIS_TVALID),
        .M_AXIS_TLAST   (M_AXIS_TLAST),
        .M_AXIS_TREADY  (M_AXIS_TREADY),
        .ctrl           (ctrl),
        .streamID       (streamID),
        .payload_len    (payload_len),
        .timestamp_sec  (timestamp_sec),
        .timestamp_fsec (timestamp_fsec),
        .pkt_sent       (pkt_sent),
        .pad_events     (pad_events),
        .status         (status),
        .Mstate_dbg     (Mstate_dbg)
    );

    initial AXIS_ACLK = 1'b0;
    always #5 AXIS_ACLK = ~AXIS_ACLK;

    function automatic logic [31:0] sw(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    // expected packet: header, stream id, optional timestamps, payload/pad
    task automatic add_pkt(input bit tsi, input bit tsf, input int len,
                           input int cnt, input int s0, input int navail);
        logic [15:0] sz;
        logic [31:0] h;
        sz = 16'(2 + (tsi ? 1 : 0) + (tsf ? 2 : 0) + len);
        h  = {4'b0001, 4'b0000, tsi ? 2'b01 : 2'b00,
              tsf ? 2'b10 : 2'b00, cnt[3:0], sz};
        exp.push_back(sw(h));        expl.push_back(1'b0);
        exp.push_back(sw(streamID)); expl.push_back(1'b0);
        if (tsi) begin
            exp.push_back(sw(timestamp_sec)); expl.push_back(1'b0);
        end
        if (tsf) begin
            exp.push_back(sw(timestamp_fsec[63:32])); expl.push_back(1'b0);
            exp.push_back(sw(timestamp_fsec[31:0]));  expl.push_back(1'b0);
        end
        for (int k = 0; k < len; k++) begin
            exp.push_back(k < navail ? sw(src[s0 + k]) : 32'd0);
            expl.push_back(k == len - 1);
        end
    endtask

    // cycle loop: feed src, collect M words until npk TLASTs seen
    task automatic run(input int npk, input bit toggle, input int maxc);
        int si, cyc, seen;
        bit pv;
        logic [31:0] pd;
        logic pl;
        si = 0; cyc = 0; seen = 0; pv = 0; pd = 0; pl = 0;
        got.delete();
        gotl.delete();
        while (seen < npk && cyc < maxc) begin
            M_AXIS_TREADY = toggle ? cyc[0] : 1'b1;
            if (si < src.size()) begin
                S_AXIS_TVALID = 1'b1;
                S_AXIS_TDATA  = src[si];
                S_AXIS_TLAST  = srcl[si];
            end else begin
                S_AXIS_TVALID = 1'b0;
                S_AXIS_TDATA  = 32'd0;
                S_AXIS_TLAST  = 1'b0;
            end
            #1;
            if (pv) begin
                checks++;
                if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== pd
                    || M_AXIS_TLAST !== pl) begin
                    failures++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, pd, pl);
                end
            end
            if (Mstate_dbg inside {[3'd1:3'd5]}) begin
                checks++;
                if (S_AXIS_TREADY !== 1'b0) begin
                    failures++;
                    $display("FAIL hdr_tready: state=%0d got %b want 0",
                             Mstate_dbg, S_AXIS_TREADY);
                end
            end
            pv = M_AXIS_TVALID && !M_AXIS_TREADY;
            pd = M_AXIS_TDATA;
            pl = M_AXIS_TLAST;
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                got.push_back(M_AXIS_TDATA);
                gotl.push_back(M_AXIS_TLAST);
                if (M_AXIS_TLAST) seen++;
            end
            if (S_AXIS_TVALID && S_AXIS_TREADY) si++;
            @(negedge AXIS_ACLK);
            cyc++;
        end
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        M_AXIS_TREADY = 1'b1;
        checks++;
        if (seen < npk) begin
            failures++;
            $display("FAIL run_timeout: got %0d packets want %0d", seen, npk);
        end
    endtask

    task automatic settle();
        repeat (2) @(negedge AXIS_ACLK);
    endtask

    task automatic test_reset();
        AXIS_ARESETN  = 1'b0;
        S_AXIS_TDATA  = 32'd0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        M_AXIS_TREADY = 1'b1;
        ctrl          = 32'd0;
        streamID      = 32'h1234_5678;
        payload_len   = 16'd4;
        timestamp_sec  = 32'hA1B2_C3D4;
        timestamp_fsec = 64'h0102_0304_0506_0708;
        #1;
        checks++;
        if (M_AXIS_TVALID !== 1'b0 || M_AXIS_TLAST !== 1'b0
            || M_AXIS_TDATA !== 32'd0) begin
            failures++;
            $display("FAIL reset_out: got v=%b l=%b d=%h want 0 0 0",
                     M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA);
        end
        checks++;
        if (pkt_sent !== 32'd0 || pad_events !== 32'd0) begin
            failures++;
            $display("FAIL reset_cnt: got sent=%0d pad=%0d want 0 0",
                     pkt_sent, pad_events);
        end
        repeat (3) @(negedge AXIS_ACLK);
        AXIS_ARESETN = 1'b1;
        @(negedge AXIS_ACLK);
        checks++;
        if (status !== 32'h1000_0000) begin
            failures++;
            $display("FAIL reset_status: got %h want 10000000", status);
        end
        checks++;
        if (Mstate_dbg !== 3'd0 || S_AXIS_TREADY !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got st=%0d rdy=%b want 0 0",
                     Mstate_dbg, S_AXIS_TREADY);
        end
    endtask

    task automatic test_full_hdr();
        ctrl        = 32'h19;
        payload_len = 16'd4;
        src  = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 32'hDDEE_FF00};
        srcl = '{1'b0, 1'b0, 1'b0, 1'b1};
        exp  = '{32'h0900_6010, 32'h7856_3412, 32'hD4C3_B2A1,
                 32'h0403_0201, 32'h0807_0605, 32'h4433_2211,
                 32'h8877_6655, 32'hCCBB_AA99, 32'h00FF_EEDD};
        expl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        settle();
        run(1, 1'b0, 60);
        checks++;
        if (got.size() !== exp.size()) begin
            failures++;
            $display("FAIL full_len: got %0d words want %0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i] || gotl[i] !== expl[i]) begin
                failures++;
                $display("FAIL full_word%0d: got %h/%b want %h/%b",
                         i, got[i], gotl[i], exp[i], expl[i]);
            end
        end
        checks++;
        if (pkt_sent !== 32'd1) begin
            failures++;
            $display("FAIL full_sent: got %0d want 1", pkt_sent);
        end
    endtask

    task automatic test_back_to_back();
        ctrl = 32'h02;
        settle();
        ctrl        = 32'h01;
        payload_len = 16'd3;
        settle();
        checks++;
        if (pkt_sent !== 32'd0 || pad_events !== 32'd0) begin
            failures++;
            $display("FAIL srst_clear: got sent=%0d pad=%0d want 0 0",
                     pkt_sent, pad_events);
        end
        src.delete();
        srcl.delete();
        for (int i = 0; i < 51; i++) begin
            src.push_back(32'hA000_0000 + i * 32'h0001_0203);
            srcl.push_back((i % 3) == 2);
        end
        exp.delete();
        expl.delete();
        for (int p = 0; p < 17; p++) add_pkt(1'b0, 1'b0, 3, p, p * 3, 3);
        run(17, 1'b0, 400);
        checks++;
        if (got.size() !== exp.size()) begin
            failures++;
            $display("FAIL b2b_len: got %0d words want %0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i] || gotl[i] !== expl[i]) begin
                failures++;
                $display("FAIL b2b_word%0d: got %h/%b want %h/%b",
                         i, got[i], gotl[i], exp[i], expl[i]);
            end
        end
        checks++;
        if (got.size() > 80 && (got[0] !== 32'h0500_0010 || got[5] !== 32'h0500_0110
            || got[75] !== 32'h0500_0F10 || got[80] !== 32'h0500_0010)) begin
            failures++;
            $display("FAIL b2b_cnt: got %h %h %h %h want 05000010 05000110 05000f10 05000010",
                     got[0], got[5], got[75], got[80]);
        end
        checks++;
        if (pkt_sent !== 32'd17) begin
            failures++;
            $display("FAIL b2b_sent: got %0d want 17", pkt_sent);
        end
    endtask

    task automatic test_pad();
        payload_len = 16'd8;
        settle();
        src  = '{32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C};
        srcl = '{1'b0, 1'b0, 1'b1};
        exp.delete();
        expl.delete();
        add_pkt(1'b0, 1'b0, 8, 1, 0, 3);
        run(1, 1'b0, 60);
        checks++;
        if (got.size() !== exp.size()) begin
            failures++;
            $display("FAIL pad_len: got %0d words want %0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i] || gotl[i] !== expl[i]) begin
                failures++;
                $display("FAIL pad_word%0d: got %h/%b want %h/%b",
                         i, got[i], gotl[i], exp[i], expl[i]);
            end
        end
        checks++;
        if (got.size() > 0 && got[0] !== 32'h0A00_0110) begin
            failures++;
            $display("FAIL pad_hdr: got %h want 0a000110", got[0]);
        end
        checks++;
        if (pad_events !== 32'd1) begin
            failures++;
            $display("FAIL pad_events: got %0d want 1", pad_events);
        end
    endtask

    task automatic test_backpressure();
        ctrl        = 32'h19;
        payload_len = 16'd16;
        settle();
        src.delete();
        srcl.delete();
        for (int i = 0; i < 16; i++) begin
            src.push_back(32'h1000_0000 + i * 32'h0101_0101);
            srcl.push_back(i == 15);
        end
        exp.delete();
        expl.delete();
        add_pkt(1'b1, 1'b1, 16, 2, 0, 16);
        run(1, 1'b1, 200);
        checks++;
        if (got.size() !== exp.size()) begin
            failures++;
            $display("FAIL bp_len: got %0d words want %0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i] || gotl[i] !== expl[i]) begin
                failures++;
                $display("FAIL bp_word%0d: got %h/%b want %h/%b",
                         i, got[i], gotl[i], exp[i], expl[i]);
            end
        end
        checks++;
        if (got.size() > 0 && got[0] !== 32'h1500_6210) begin
            failures++;
            $display("FAIL bp_hdr: got %h want 15006210", got[0]);
        end
    endtask

    task automatic test_async_reset();
        int acc;
        bit hit;
        acc = 0;
        hit = 0;
        ctrl        = 32'h01;
        payload_len = 16'd4;
        settle();
        M_AXIS_TREADY = 1'b1;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = 32'h5A5A_0001;
        S_AXIS_TLAST  = 1'b0;
        for (int c = 0; c < 30 && !hit; c++) begin
            @(negedge AXIS_ACLK);
            #1;
            if (Mstate_dbg == 3'd6 && acc == 1) hit = 1;
            else if (S_AXIS_TVALID && S_AXIS_TREADY) acc++;
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL arst_reach: got acc=%0d want payload word 2", acc);
        end
        AXIS_ARESETN = 1'b0;
        #1;
        checks++;
        if (M_AXIS_TVALID !== 1'b0 || M_AXIS_TLAST !== 1'b0
            || M_AXIS_TDATA !== 32'd0 || Mstate_dbg !== 3'd0) begin
            failures++;
            $display("FAIL arst_now: got v=%b l=%b d=%h st=%0d want 0 0 0 0",
                     M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, Mstate_dbg);
        end
        S_AXIS_TVALID = 1'b0;
        @(negedge AXIS_ACLK);
        AXIS_ARESETN = 1'b1;
        payload_len  = 16'd1;
        settle();
        src  = '{32'hCAFE_F00D};
        srcl = '{1'b1};
        exp  = '{32'h0300_0010, 32'h7856_3412, 32'h0DF0_FECA};
        expl = '{1'b0, 1'b0, 1'b1};
        run(1, 1'b0, 40);
        checks++;
        if (got.size() !== exp.size()) begin
            failures++;
            $display("FAIL arst_len: got %0d words want %0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i] || gotl[i] !== expl[i]) begin
                failures++;
                $display("FAIL arst_word%0d: got %h/%b want %h/%b",
                         i, got[i], gotl[i], exp[i], expl[i]);
            end
        end
        checks++;
        if (pkt_sent !== 32'd1) begin
            failures++;
            $display("FAIL arst_sent: got %0d want 1", pkt_sent);
        end
    endtask

    task automatic test_passthrough();
        ctrl = 32'h04;
        settle();
        S_AXIS_TDATA  = 32'hDEAD_BEEF;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TLAST  = 1'b1;
        M_AXIS_TREADY = 1'b0;
        #1;
        checks++;
        if (M_AXIS_TDATA !== 32'hDEAD_BEEF || M_AXIS_TVALID !== 1'b1
            || M_AXIS_TLAST !== 1'b1 || S_AXIS_TREADY !== 1'b0) begin
            failures++;
            $display("FAIL pt_mirror: got d=%h v=%b l=%b r=%b want deadbeef 1 1 0",
                     M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST, S_AXIS_TREADY);
        end
        M_AXIS_TREADY = 1'b1;
        #1;
        checks++;
        if (S_AXIS_TREADY !== 1'b1) begin
            failures++;
            $display("FAIL pt_ready: got %b want 1", S_AXIS_TREADY);
        end
        @(negedge AXIS_ACLK);
        checks++;
        if (status !== 32'h3000_0000 || pkt_sent !== 32'd1) begin
            failures++;
            $display("FAIL pt_status: got st=%h sent=%0d want 30000000 1",
                     status, pkt_sent);
        end
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        ctrl = 32'h00;
        settle();
    endtask

    task automatic test_len_clamp();
        ctrl        = 32'h01;
        payload_len = 16'd0;
        settle();
        src  = '{32'h0BAD_BEEF};
        srcl = '{1'b0};
        exp  = '{32'h0300_0110, 32'h7856_3412, 32'hEFBE_AD0B};
        expl = '{1'b0, 1'b0, 1'b1};
        run(1, 1'b0, 40);
        checks++;
        if (got.size() !== exp.size()) begin
            failures++;
            $display("FAIL clamp_len: got %0d words want %0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i] || gotl[i] !== expl[i]) begin
                failures++;
                $display("FAIL clamp_word%0d: got %h/%b want %h/%b",
                         i, got[i], gotl[i], exp[i], expl[i]);
            end
        end
        checks++;
        if (pkt_sent !== 32'd2) begin
            failures++;
            $display("FAIL clamp_sent: got %0d want 2", pkt_sent);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_full_hdr();
        test_back_to_back();
        test_pad();
        test_backpressure();
        test_async_reset();
        test_passthrough();
        test_len_clamp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
